// File: rtl/acc_frame_feeder.sv
// Frame feeder: buffers an input sample stream in a FIFO and issues frames of len samples to the accumulator.
// Optional WAIT-state watchdog with sticky timeout output is built when ACC_FEEDER_WDOG_EN is defined.
module acc_frame_feeder #(
  parameter int width = 32,
  parameter int len   = 16,
  parameter int depth = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [width-1:0]           in_data,
  output logic                       start,
  output logic                       data_rdy,
  output logic [width-1:0]           indata,
  input  logic                       cal_done,
  output logic                       busy,
  output logic [$clog2(depth):0]     fill,
  output logic [15:0]                frame_cnt
`ifdef ACC_FEEDER_WDOG_EN
  ,
  output logic                       timeout
`endif
);

  localparam int AW = $clog2(depth);
  localparam int FW = AW + 1;
  localparam int BW = $clog2(len + 1);
`ifdef ACC_FEEDER_WDOG_EN
  localparam int WD_LIMIT = 2 * len + 8;
  localparam int WW = $clog2(WD_LIMIT);
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [width-1:0]  mem_q [depth];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              start_q, start_d;
  logic              data_rdy_q, data_rdy_d;
  logic [width-1:0]  indata_q, indata_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              push, pop;
`ifdef ACC_FEEDER_WDOG_EN
  logic [WW-1:0]     wd_q, wd_d;
  logic              timeout_q, timeout_d;
`endif

  assign in_ready  = (fill_q != FW'(depth));
  assign push      = in_valid && in_ready;
  assign start     = start_q;
  assign data_rdy  = data_rdy_q;
  assign indata    = indata_q;
  assign busy      = (state_q != S_IDLE);
  assign fill      = fill_q;
  assign frame_cnt = frame_cnt_q;
`ifdef ACC_FEEDER_WDOG_EN
  assign timeout   = timeout_q;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    start_d     = 1'b0;
    data_rdy_d  = 1'b0;
    indata_d    = indata_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
`ifdef ACC_FEEDER_WDOG_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (fill_q >= FW'(len)) begin
          state_d = S_START;
          start_d = 1'b1;
        end
      end
      // First word is popped here so the beat lands in the cycle right after start;
      // beat_q then counts the beats still to issue.
      S_START: begin
        state_d    = S_STREAM;
        pop        = 1'b1;
        data_rdy_d = 1'b1;
        indata_d   = mem_q[rd_ptr_q];
        beat_d     = BW'(len - 1);
      end
      S_STREAM: begin
        if (beat_q != '0) begin
          pop        = 1'b1;
          data_rdy_d = 1'b1;
          indata_d   = mem_q[rd_ptr_q];
          beat_d     = beat_q - 1'b1;
        end else begin
          state_d = S_WAIT;
`ifdef ACC_FEEDER_WDOG_EN
          wd_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (cal_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
`ifdef ACC_FEEDER_WDOG_EN
        else if (wd_q == WW'(WD_LIMIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      beat_q      <= '0;
      start_q     <= 1'b0;
      data_rdy_q  <= 1'b0;
      indata_q    <= '0;
      frame_cnt_q <= '0;
`ifdef ACC_FEEDER_WDOG_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      beat_q      <= beat_d;
      start_q     <= start_d;
      data_rdy_q  <= data_rdy_d;
      indata_q    <= indata_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef ACC_FEEDER_WDOG_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_acc_frame_feeder.sv
// Self-checking bench for acc_frame_feeder: queue-based frame reference model with randomized sample data.
// Watchdog checks are included when ACC_FEEDER_WDOG_EN is defined.
module tb_acc_frame_feeder;

  localparam int LEN   = 16;
  localparam int DEPTH = 32;
  localparam int WD    = 2 * LEN + 8;
  localparam int M_IDLE = 0, M_START = 1, M_STREAM = 2, M_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        start;
  logic        data_rdy;
  logic [31:0] indata;
  logic        cal_done = 1'b0;
  logic        busy;
  logic [5:0]  fill;
  logic [15:0] frame_cnt;
`ifdef ACC_FEEDER_WDOG_EN
  logic        timeout;
`endif

  acc_frame_feeder #(.width(32), .len(LEN), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .data_rdy(data_rdy), .indata(indata), .cal_done(cal_done),
    .busy(busy), .fill(fill), .frame_cnt(frame_cnt)
`ifdef ACC_FEEDER_WDOG_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: samples held in a queue, frame phase tracked per cycle.
  logic [31:0] m_q [$];
  int          m_fill = 0;
  int          m_mode = M_IDLE;
  int          m_beat = 0;
  logic [31:0] m_data = '0;
  logic [15:0] m_frames = '0;
  logic        m_timeout = 1'b0;
  int          cyc = 0;
  int          m_went = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] d, input logic cd, input logic r);
    logic acc;
    in_valid = v;
    in_data  = d;
    cal_done = cd;
    rst      = r;
    acc = v && (m_fill != DEPTH);
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_q.delete();
      m_fill = 0; m_mode = M_IDLE; m_frames = '0; m_timeout = 1'b0; m_data = '0;
    end else begin
      case (m_mode)
        M_IDLE:  if (m_fill >= LEN) m_mode = M_START;
        M_START: begin
          m_mode = M_STREAM; m_beat = 1; m_data = m_q.pop_front(); m_fill--;
        end
        M_STREAM: begin
          if (m_beat == LEN) begin
            m_mode = M_WAIT; m_went = cyc;
          end else begin
            m_beat++; m_data = m_q.pop_front(); m_fill--;
          end
        end
        default: begin
          if (cd) begin
            m_frames = m_frames + 16'd1; m_mode = M_IDLE;
          end
`ifdef ACC_FEEDER_WDOG_EN
          else if (cyc - m_went == WD) begin
            m_timeout = 1'b1; m_mode = M_IDLE;
          end
`endif
        end
      endcase
      if (acc) begin
        m_q.push_back(d); m_fill++;
      end
    end
    in_valid = 1'b0;
    cal_done = 1'b0;
    chk("start", 32'(start), 32'(m_mode == M_START));
    chk("data_rdy", 32'(data_rdy), 32'(m_mode == M_STREAM));
    if (m_mode == M_STREAM) chk("indata", indata, m_data);
    chk("fill", 32'(fill), 32'(m_fill));
    chk("in_ready", 32'(in_ready), 32'(m_fill != DEPTH));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
`ifdef ACC_FEEDER_WDOG_EN
    chk("timeout", 32'(timeout), 32'(m_timeout));
`endif
  endtask

  initial begin
    logic done;
    logic cdv;
    int   tcyc;

    // Reset state
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fill", 32'(fill), 32'd0);

    // Frame of 1..16, cal_done three cycles after the last beat
    for (int i = 1; i <= 16; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      cdv = (m_mode == M_WAIT) && (cyc - m_went == 2);
      tick(1'b0, '0, cdv, 1'b0);
      done = cdv;
    end
    chk("a_reached", 32'(done), 32'd1);
    chk("a_frames", 32'(frame_cnt), 32'd1);
    chk("a_busy", 32'(busy), 32'd0);

    // Fill to capacity while the next frame waits for cal_done
    done = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      tick(1'b1, $urandom, 1'b0, 1'b0);
      done = (m_mode == M_WAIT) && (m_fill == DEPTH);
    end
    chk("b_reached", 32'(done), 32'd1);
    tick(1'b1, $urandom, 1'b0, 1'b0);
    chk("b_full_fill", 32'(fill), 32'd32);
    chk("b_full_ready", 32'(in_ready), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1'b0, '0, (m_mode == M_WAIT) && (cyc - m_went == 1), 1'b0);
      done = (m_mode == M_IDLE) && (m_fill == 0);
    end
    chk("b_drained", 32'(done), 32'd1);
    chk("b_frames", 32'(frame_cnt), 32'd4);

    // Continuous input, five frames with cal_done two cycles after last beat
    for (int i = 0; i < 800 && m_frames != 16'd9; i++)
      tick(1'b1, $urandom, (m_mode == M_WAIT) && (cyc - m_went == 1), 1'b0);
    chk("c_frames", 32'(frame_cnt), 32'd9);

    // Reset on the 8th beat aborts the frame
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < LEN; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      done = (m_mode == M_STREAM) && (m_beat == 8);
      if (!done) tick(1'b1, $urandom, 1'b0, 1'b0);
    end
    chk("d_reached", 32'(done), 32'd1);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("d_rdy_after_rst", 32'(data_rdy), 32'd0);
    chk("d_fill_after_rst", 32'(fill), 32'd0);
    for (int i = 0; i < LEN; i++) tick($urandom_range(0, 3) != 0, $urandom, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      cdv = (m_mode == M_WAIT) && (cyc - m_went == 1);
      tick((m_mode == M_IDLE) && (m_fill < LEN), $urandom, cdv, 1'b0);
      done = cdv;
    end
    chk("d_frames", 32'(frame_cnt), 32'd1);

`ifdef ACC_FEEDER_WDOG_EN
    // Withheld cal_done trips the watchdog 40 cycles after WAIT entry
    while (m_fill > 0 && m_fill < LEN) tick(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) tick(m_fill < LEN, $urandom, 1'b0, 1'b0);
    tcyc = -1;
    for (int i = 0; i < 120 && tcyc < 0; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      if (timeout === 1'b1) tcyc = cyc;
    end
    chk("e_delay", 32'(tcyc - m_went), 32'(WD));
    chk("e_timeout", 32'(timeout), 32'd1);
    chk("e_frames", 32'(frame_cnt), 32'd1);
    chk("e_busy", 32'(busy), 32'd0);
`else
    tcyc = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
